// File: rtl/rst_seq_gen_if.sv
// rtl/rst_seq_gen_if.sv - request/reset bundle between a reset controller and rst_seq_gen
//
// Purpose: groups the reset request inputs and the sequenced reset outputs
//          of rst_seq_gen so they can be passed as one port.
// Signals:
//   i_sw_req  software reset request (level)
//   i_wdt_req watchdog reset request (level)
//   i_hold    keep all resets asserted while high
//   o_rstn    sequenced active-low resets, bit 0 releases first
//   o_busy    high while any o_rstn bit is low
//   o_done    one-cycle pulse when the last stage releases
//   o_cause   last reset cause: 00 POR, 01 SW, 10 WDT, 11 HOLD
// Modports: master = request source / reset consumer, slave = sequencer.
interface rst_seq_gen_if #(
  parameter int NUM_RST = 4
) ();
  logic               i_sw_req;
  logic               i_wdt_req;
  logic               i_hold;
  logic [NUM_RST-1:0] o_rstn;
  logic               o_busy;
  logic               o_done;
  logic [1:0]         o_cause;

  modport master (
    output i_sw_req, i_wdt_req, i_hold,
    input  o_rstn, o_busy, o_done, o_cause
  );

  modport slave (
    input  i_sw_req, i_wdt_req, i_hold,
    output o_rstn, o_busy, o_done, o_cause
  );
endinterface

// File: rtl/rst_seq_gen.sv
// rtl/rst_seq_gen.sv - staged reset sequencer driving per-domain reset synchronizers
//
// Purpose: asserts a bank of active-low resets together on power-on, software,
//          watchdog or hold requests, keeps them asserted for HOLD_CYC clean
//          cycles, then releases them one at a time (bit 0 first) GAP_CYC
//          cycles apart. Every output is a flop.
// Ports:
//   i_clk  system clock
//   i_rst  synchronous active-high reset
//   bus    rst_seq_gen_if.slave: i_sw_req, i_wdt_req, i_hold in;
//          o_rstn, o_busy, o_done, o_cause out
module rst_seq_gen #(
  parameter int NUM_RST  = 4,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  rst_seq_gen_if.slave bus
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);
  localparam int IDX_W  = $clog2(NUM_RST + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_TERM = HOLD_W'(HOLD_CYC);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_RST - 1);
  localparam logic [NUM_RST-1:0] RSTN_ONE  = NUM_RST'(1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t             r_state;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_RST-1:0] r_rstn;
  logic               r_busy;
  logic               r_done;
  logic [1:0]         r_cause;

  logic       w_req_any;
  logic [1:0] w_abort_cause;

  assign w_req_any = bus.i_wdt_req | bus.i_sw_req | bus.i_hold;

  // Priority wdt > sw > hold; 11 only when hold is the sole source.
  assign w_abort_cause = bus.i_wdt_req ? 2'b10 :
                         bus.i_sw_req  ? 2'b01 : 2'b11;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_ASSERT;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_idx      <= '0;
      r_rstn     <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_cause    <= 2'b00;
    end else if (r_state != ST_ASSERT && w_req_any) begin
      // Abort from RELEASE/RUN: reassert everything on this same edge.
      r_state    <= ST_ASSERT;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_idx      <= '0;
      r_rstn     <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_cause    <= w_abort_cause;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          r_rstn <= '0;
          r_busy <= 1'b1;
          r_done <= 1'b0;
          if (w_req_any) begin
            // Any request restarts the hold time; hold alone keeps the cause.
            r_hold_cnt <= '0;
            if (bus.i_wdt_req)     r_cause <= 2'b10;
            else if (bus.i_sw_req) r_cause <= 2'b01;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= HOLD_TERM;
            r_rstn     <= RSTN_ONE;
            r_gap_cnt  <= '0;
            r_idx      <= IDX_W'(1);
            if (NUM_RST == 1) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RELEASE;
            end
          end else if (r_hold_cnt != HOLD_TERM) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (r_gap_cnt == GAP_LAST) begin
            // Thermometer shift keeps release order strictly monotonic.
            r_rstn    <= (r_rstn << 1) | RSTN_ONE;
            r_idx     <= r_idx + 1'b1;
            r_gap_cnt <= '0;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          r_rstn <= '1;
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end

        default: begin
          r_state <= ST_ASSERT;
          r_rstn  <= '0;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_rstn  = r_rstn;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
  assign bus.o_cause = r_cause;

endmodule

// File: tb/tb_rst_seq_gen.sv
// tb/tb_rst_seq_gen.sv - directed self-checking bench for rst_seq_gen
module tb_rst_seq_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rst_seq_gen_if #(.NUM_RST(4)) u_if ();
  rst_seq_gen_if #(.NUM_RST(1)) u_if1 ();

  rst_seq_gen #(.NUM_RST(4), .HOLD_CYC(16), .GAP_CYC(8)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if.slave)
  );

  rst_seq_gen #(.NUM_RST(1), .HOLD_CYC(1), .GAP_CYC(1)) u_dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_main(input string tag, input logic [3:0] rstn, input logic busy,
                          input logic done, input logic [1:0] cause);
    chk({tag, ".rstn"},  32'(u_if.o_rstn),  32'(rstn));
    chk({tag, ".busy"},  32'(u_if.o_busy),  32'(busy));
    chk({tag, ".done"},  32'(u_if.o_done),  32'(done));
    chk({tag, ".cause"}, 32'(u_if.o_cause), 32'(cause));
  endtask

  initial begin
    u_if.i_sw_req   = 1'b0;
    u_if.i_wdt_req  = 1'b0;
    u_if.i_hold     = 1'b0;
    u_if1.i_sw_req  = 1'b0;
    u_if1.i_wdt_req = 1'b0;
    u_if1.i_hold    = 1'b0;

    // Power-on reset: 3 edges with i_rst high.
    rst = 1'b1;
    tick(3);
    chk_main("por", 4'b0000, 1'b1, 1'b0, 2'b00);
    chk("por.n1_rstn", 32'(u_if1.o_rstn), 32'h0);
    chk("por.n1_busy", 32'(u_if1.o_busy), 32'h1);

    // Default sequence: release at edges 16/24/32/40 after reset drops.
    rst = 1'b0;
    tick(1);
    chk("n1.rise_rstn", 32'(u_if1.o_rstn), 32'h1);
    chk("n1.rise_done", 32'(u_if1.o_done), 32'h1);
    chk("n1.rise_busy", 32'(u_if1.o_busy), 32'h0);
    tick(1);
    chk("n1.done_clr", 32'(u_if1.o_done), 32'h0);
    chk("n1.stay_rstn", 32'(u_if1.o_rstn), 32'h1);
    tick(13);
    chk_main("e15", 4'b0000, 1'b1, 1'b0, 2'b00);
    tick(1);
    chk_main("e16", 4'b0001, 1'b1, 1'b0, 2'b00);
    tick(7);
    chk_main("e23", 4'b0001, 1'b1, 1'b0, 2'b00);
    tick(1);
    chk_main("e24", 4'b0011, 1'b1, 1'b0, 2'b00);
    tick(8);
    chk_main("e32", 4'b0111, 1'b1, 1'b0, 2'b00);
    tick(7);
    chk_main("e39", 4'b0111, 1'b1, 1'b0, 2'b00);
    tick(1);
    chk_main("e40", 4'b1111, 1'b0, 1'b1, 2'b00);
    tick(1);
    chk_main("run", 4'b1111, 1'b0, 1'b0, 2'b00);

    // One-cycle software request in RUN.
    u_if.i_sw_req = 1'b1;
    tick(1);
    u_if.i_sw_req = 1'b0;
    chk_main("sw.abort", 4'b0000, 1'b1, 1'b0, 2'b01);
    tick(15);
    chk_main("sw.e15", 4'b0000, 1'b1, 1'b0, 2'b01);
    tick(1);
    chk_main("sw.e16", 4'b0001, 1'b1, 1'b0, 2'b01);
    tick(8);
    chk_main("sw.e24", 4'b0011, 1'b1, 1'b0, 2'b01);

    // sw + wdt together during RELEASE: wdt wins.
    u_if.i_sw_req  = 1'b1;
    u_if.i_wdt_req = 1'b1;
    tick(1);
    u_if.i_sw_req  = 1'b0;
    u_if.i_wdt_req = 1'b0;
    chk_main("wdt.abort", 4'b0000, 1'b1, 1'b0, 2'b10);
    tick(15);
    chk_main("wdt.e15", 4'b0000, 1'b1, 1'b0, 2'b10);
    tick(1);
    chk_main("wdt.e16", 4'b0001, 1'b1, 1'b0, 2'b10);
    tick(24);
    chk_main("wdt.e40", 4'b1111, 1'b0, 1'b1, 2'b10);
    tick(1);

    // Hold asserted in RUN: cause 11, restart after hold drops.
    u_if.i_hold = 1'b1;
    tick(1);
    chk_main("hold.abort", 4'b0000, 1'b1, 1'b0, 2'b11);
    tick(5);
    chk_main("hold.stay", 4'b0000, 1'b1, 1'b0, 2'b11);
    u_if.i_hold = 1'b0;
    tick(15);
    chk_main("hold.e15", 4'b0000, 1'b1, 1'b0, 2'b11);
    tick(1);
    chk_main("hold.e16", 4'b0001, 1'b1, 1'b0, 2'b11);

    // Reset again, then hold during ASSERT for 10 edges: first release at edge 26.
    rst = 1'b1;
    tick(1);
    chk_main("rst2", 4'b0000, 1'b1, 1'b0, 2'b00);
    rst = 1'b0;
    u_if.i_hold = 1'b1;
    tick(10);
    u_if.i_hold = 1'b0;
    tick(15);
    chk_main("ahold.e25", 4'b0000, 1'b1, 1'b0, 2'b00);
    tick(1);
    chk_main("ahold.e26", 4'b0001, 1'b1, 1'b0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
Reset sequencer on the generating side of the per-domain reset synchronizers. It produces a bank of registered active-low reset outputs. All outputs assert together on power-on reset, software request, watchdog request or hold. They are held for a minimum time, then released one at a time in ascending index order with a fixed gap between releases. Each output feeds the i_rstn input of a downstream per-domain synchronizer.

Parameters:
NUM_RST, 4, number of sequenced reset outputs (>=1)
HOLD_CYC, 16, minimum consecutive clean cycles in ASSERT before the first release (>=1)
GAP_CYC, 8, cycles between successive stage releases (>=1)

Ports:
i_clk  input  1  system clock, single domain
i_rst  input  1  reset, synchronous, active-high
i_sw_req  input  1  software reset request, level-sensitive, sampled every edge
i_wdt_req  input  1  watchdog reset request, level-sensitive, sampled every edge
i_hold  input  1  keep resets asserted, e.g. PLL not locked
o_rstn  output  NUM_RST  sequenced active-low resets; bit 0 releases first
o_busy  output  1  high while any o_rstn bit is low
o_done  output  1  one-cycle pulse when the last stage releases
o_cause  output  2  last reset cause: 00 POR, 01 SW, 10 WDT, 11 HOLD

Behaviour:
- All outputs are flops; no combinational path from any input to any output.
- i_rst high at an edge:
  - state=ASSERT, o_rstn=all 0, o_busy=1, o_done=0, o_cause=00.
  - hold counter and gap counter =0; stage index=0.
- States: ASSERT, RELEASE, RUN.
- Request priority at one edge: i_wdt_req > i_sw_req > i_hold.
- Cause update: a request (wdt or sw) seen in any state sets o_cause to 10 or 01.
- ASSERT:
  - o_rstn=all 0.
  - Any of i_sw_req/i_wdt_req/i_hold high -> hold counter cleared. Cause updated for wdt/sw only; hold alone does not change o_cause here.
  - Otherwise the hold counter increments.
  - On the HOLD_CYC-th consecutive clean edge: o_rstn[0]<=1, gap counter=0, stage index=1, go to RELEASE.
  - If NUM_RST==1, go to RUN instead, with the done behaviour below.
- RELEASE:
  - The gap counter increments each clean edge.
  - On the GAP_CYC-th edge: o_rstn[index]<=1, index++, gap counter=0.
  - On the edge that releases bit NUM_RST-1: go to RUN, o_busy<=0, o_done<=1.
- RUN:
  - o_rstn=all 1, o_busy=0.
  - o_done is high only for the first cycle after entering RUN.
- Abort from RELEASE or RUN on any wdt/sw/hold at an edge:
  - Same edge: o_rstn<=all 0, o_busy<=1, o_done<=0, counters and index cleared, go to ASSERT.
  - o_cause<=10/01/11 by priority (11 only when hold is the sole source).
- Request held high: the block stays in ASSERT; the hold time restarts only after the request drops.
- Release order is strictly monotonic. A higher-index bit is never 1 while a lower-index bit is 0.
- Counter widths: clog2(HOLD_CYC+1) and clog2(GAP_CYC+1), no wrap. Counters saturate at their terminal count.
- o_cause keeps its value through RUN until the next cause event; only i_rst returns it to 00.

Test Plan:
- i_rst high 3 cycles, then low with i_hold/requests=0 (defaults):
  - o_rstn[0] rises at edge 16 after the first i_rst-low edge; [1] at 24, [2] at 32, [3] at 40.
  - o_done high the cycle after edge 40; o_busy falls with it; o_cause=00.
- i_hold high for edges 0-9, low thereafter -> o_rstn[0] rises at edge 26; o_cause stays 00.
- In RUN, 1-cycle i_sw_req pulse:
  - Next edge: o_rstn=0000, o_busy=1, o_cause=01.
  - o_rstn[0] rises 16 edges after the pulse edge, followed by the full 8-cycle gap sequence.
- During RELEASE, after o_rstn=0011, i_sw_req and i_wdt_req asserted together -> o_rstn=0000 next edge, o_cause=10, sequence restarts from bit 0.
- In RUN, i_hold asserted -> o_cause=11, all outputs asserted. Release o_rstn[0] only after 16 clean edges once i_hold drops.
- NUM_RST=1, HOLD_CYC=1, GAP_CYC=1 -> o_rstn[0] rises 1 edge after reset release; o_done pulses on the following cycle.
